// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential PC generator issuing credit-limited imem requests into a flushable prefetch FIFO.
// A redirect empties the queue; responses for requests still in flight at that point are counted and discarded.
module fetch_prefetch_queue #(
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [ADDR_W-1:0]          imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INSTR_W-1:0]         imem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       misalign_err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      outst_q, outst_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d, pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
    logic               misalign_q, misalign_d;
    logic [ADDR_W-1:0]  q_pc_q [DEPTH];
    logic [ADDR_W-1:0]  q_pc_d [DEPTH];
    logic [INSTR_W-1:0] q_instr_q [DEPTH];
    logic [INSTR_W-1:0] q_instr_d [DEPTH];
    logic [ADDR_W-1:0]  pf_q [DEPTH];
    logic [ADDR_W-1:0]  pf_d [DEPTH];
    logic               rsp_ok, accept, push, pop;

    always_comb begin
        rsp_ok = imem_rsp_valid && outst_q != '0;
        imem_req_valid = reset && !redirect_valid && ({1'b0, count_q} + {1'b0, outst_q} < DEPTH_C);
        accept = imem_req_valid && imem_req_ready;
        out_valid = count_q != '0 && !redirect_valid;
        pop = out_valid && out_ready;
        push = rsp_ok && drop_q == '0 && !redirect_valid;
        imem_req_addr = fetch_pc_q;
        out_instr = q_instr_q[rd_q];
        out_pc = q_pc_q[rd_q];
        occupancy = count_q;
        misalign_err = misalign_q;
        fetch_pc_d = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00}
                   : accept ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
        misalign_d = redirect_valid && |redirect_pc[1:0];
        outst_d = outst_q + CW'(accept) - CW'(rsp_ok);
        // every request still in flight at a redirect belongs to the abandoned path
        drop_d = redirect_valid ? outst_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wr_d = redirect_valid ? '0 : wr_q + PW'(push);
        rd_d = redirect_valid ? '0 : rd_q + PW'(pop);
        pf_wr_d = pf_wr_q + PW'(accept);
        pf_rd_d = pf_rd_q + PW'(rsp_ok);
        q_pc_d = q_pc_q;
        q_instr_d = q_instr_q;
        pf_d = pf_q;
        if (push) begin
            q_pc_d[wr_q] = pf_q[pf_rd_q];
            q_instr_d[wr_q] = imem_rsp_data;
        end
        if (accept) pf_d[pf_wr_q] = fetch_pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            outst_q <= '0;
            drop_q <= '0;
            count_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            pf_wr_q <= '0;
            pf_rd_q <= '0;
            misalign_q <= 1'b0;
            q_pc_q <= '{default: '0};
            q_instr_q <= '{default: '0};
            pf_q <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q <= outst_d;
            drop_q <= drop_d;
            count_q <= count_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            pf_wr_q <= pf_wr_d;
            pf_rd_q <= pf_rd_d;
            misalign_q <= misalign_d;
            q_pc_q <= q_pc_d;
            q_instr_q <= q_instr_d;
            pf_q <= pf_d;
        end
    end
endmodule
